// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_program_loader
// Purpose  : Receives a program image over an 8N1 UART line and writes it,
//            one byte per address, into an instruction memory. A load is
//            started (or restarted) with Load and completes after Depth
//            valid bytes, signalled by a one-cycle Done pulse.
// Ports    : Clk      - clock, rising edge
//            Reset    - synchronous active-high reset
//            Load     - start/restart a program load
//            RX       - asynchronous serial input, idle high
//            Wr_en    - one-cycle instruction-memory write strobe
//            Wr_addr  - write address
//            Wr_data  - received byte (holds when Wr_en is low)
//            Busy     - load in progress
//            Done     - pulses with the final write of a load
//            FE       - sticky framing-error flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_program_loader #(
  parameter int Baudrate = 24,
  parameter int Depth    = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       RX,
  output logic       Wr_en,
  output logic [4:0] Wr_addr,
  output logic [7:0] Wr_data,
  output logic       Busy,
  output logic       Done,
  output logic       FE
);

  localparam int              CNT_W     = $clog2(Baudrate);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Baudrate / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(Baudrate - 1);
  localparam logic [4:0]       ADDR_LAST = 5'(Depth - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fe_q, fe_d;
  logic             rx;

  assign rx = rx_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    fe_d    = fe_q;

    // The address advances the cycle after a strobe, except after the final
    // strobe of a load, where it parks on the last address.
    if (wr_en_q && !done_q) begin
      addr_d = addr_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
      end
      HUNT: begin
        if (!rx) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx ? HUNT : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            wr_en_d = 1'b1;
            data_d  = shift_q;
            if (addr_q == ADDR_LAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = HUNT;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A held-low line must return high before a new start bit counts.
        if (rx) begin
          state_d = HUNT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Load overrides everything, including a write due this cycle.
    if (Load) begin
      state_d = HUNT;
      cnt_d   = '0;
      bit_d   = 3'd0;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      addr_d  = 5'd0;
      data_d  = data_q;
      fe_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      wr_en_q <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
    end
  end

  assign Wr_en   = wr_en_q;
  assign Wr_addr = addr_q;
  assign Wr_data = data_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign FE      = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_program_loader
// Purpose  : Self-checking bench for uart_program_loader. Directed frame
//            table, multi-cycle corner sequences (glitch, abort, reset,
//            full load) and randomized frames against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

  localparam int B = 24;
  localparam int D = 32;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic       Load  = 1'b0;
  logic       RX    = 1'b1;
  logic       Wr_en;
  logic [4:0] Wr_addr;
  logic [7:0] Wr_data;
  logic       Busy;
  logic       Done;
  logic       FE;

  uart_program_loader #(.Baudrate(B), .Depth(D)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .RX(RX),
    .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
    .Busy(Busy), .Done(Done), .FE(FE)
  );

  always #5 Clk = ~Clk;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  int last_wr_cyc = 0;
  int stray_done = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;
  wr_t wq[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Collect every write strobe; Done without a strobe is an error.
  always @(negedge Clk) begin
    if (Wr_en) begin
      wq.push_back({Wr_addr, Wr_data, Done});
      last_wr_cyc = cyc;
    end else if (Done) begin
      stray_done++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_event(input int kind);
    if (kind == 1) begin
      Load = 1'b1;
      @(negedge Clk);
      check("abort_addr", Wr_addr, 0);
      check("abort_fe", FE, 0);
      check("abort_busy", Busy, 1);
      check("abort_wren", Wr_en, 0);
      Load = 1'b0;
    end else begin
      Reset = 1'b1;
      @(negedge Clk);
      check("midrst_outputs", {Wr_en, Wr_addr, Wr_data, Busy, Done, FE}, 0);
      Reset = 1'b0;
    end
  endtask

  // One 8N1 frame; optional extra low time after the stop bit and an
  // optional Load (kind 1) or Reset (kind 2) in the middle of bit ev_idx
  // (0 = start bit, 1..8 = data bits).
  task automatic send_frame(input logic [7:0] data, input logic stop, input int low_bits,
                            input int ev_idx, input int ev_kind);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    @(negedge Clk);
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      for (int c = 0; c < B; c++) begin
        if (i == ev_idx && c == B / 2 && ev_kind != 0) do_event(ev_kind);
        else @(negedge Clk);
      end
    end
    if (low_bits > 0) begin
      RX = 1'b0;
      repeat (low_bits * B) @(negedge Clk);
    end
    RX = 1'b1;
    repeat (2 * B) @(negedge Clk);
  endtask

  task automatic load_pulse();
    @(negedge Clk);
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic exp_wr, input logic [4:0] exp_addr,
                             input logic [7:0] exp_data, input logic exp_done);
    wr_t w;
    check({name, "_wrcount"}, wq.size(), exp_wr ? 1 : 0);
    if (exp_wr && wq.size() > 0) begin
      w = wq.pop_front();
      check({name, "_addr"}, w.addr, exp_addr);
      check({name, "_data"}, w.data, exp_data);
      check({name, "_done"}, w.done, exp_done);
    end
    wq.delete();
  endtask

  // Byte-level reference: a load accepts Depth good frames in order,
  // bad frames only raise FE, nothing is accepted outside a load.
  logic m_active = 1'b0;
  int   m_cnt    = 0;
  logic m_fe     = 1'b0;
  int   m_wa     = 0;

  task automatic model_load();
    m_active = 1'b1; m_cnt = 0; m_fe = 1'b0; m_wa = 0;
  endtask

  task automatic model_frame(input logic stop, output logic ew, output logic [4:0] ea,
                             output logic ed);
    ew = 1'b0; ea = 5'd0; ed = 1'b0;
    if (m_active) begin
      if (stop) begin
        ew = 1'b1;
        ea = 5'(m_cnt);
        m_cnt++;
        ed = (m_cnt == D);
        if (ed) begin m_active = 1'b0; m_wa = D - 1; end
        else m_wa = m_cnt;
      end else begin
        m_fe = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       load;
    int         low;
    logic       exp_wr;
    logic [4:0] exp_addr;
    logic       exp_fe;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic       ew, ed;
    logic [4:0] ea;
    logic [7:0] d;
    logic       s;
    int         lat;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 0,   1'b1, 5'd0, 1'b0};
    tbl[1] = '{8'h5A, 1'b1, 1'b0, 0,   1'b1, 5'd1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 100, 1'b0, 5'd0, 1'b1};
    tbl[3] = '{8'h7E, 1'b1, 1'b0, 0,   1'b1, 5'd0, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 0,   1'b1, 5'd0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 0,   1'b1, 5'd1, 1'b0};

    repeat (3) @(negedge Clk);
    check("reset_outputs", {Wr_en, Wr_addr, Wr_data, Busy, Done, FE}, 0);
    Reset = 1'b0;

    // Without a Load the line is ignored.
    send_frame(8'h55, 1'b1, 0, -1, 0);
    check_frame("idle_ignored", 1'b0, 5'd0, 8'h00, 1'b0);
    check("idle_busy", Busy, 0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].load) load_pulse();
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].low, -1, 0);
      if (i == 0) begin
        lat = last_wr_cyc - start_cyc;
        check("a5_latency_in_range", (lat >= 226 && lat <= 236), 1);
      end
      check_frame($sformatf("tbl%0d", i), tbl[i].exp_wr, tbl[i].exp_addr, tbl[i].data, 1'b0);
      check($sformatf("tbl%0d_fe", i), FE, tbl[i].exp_fe);
      check($sformatf("tbl%0d_busy", i), Busy, 1);
      check($sformatf("tbl%0d_wraddr", i), Wr_addr,
            tbl[i].exp_wr ? tbl[i].exp_addr + 5'd1 : tbl[i].exp_addr);
      if (tbl[i].exp_wr) check($sformatf("tbl%0d_wrdata", i), Wr_data, tbl[i].data);
    end

    // Short low glitch while hunting: rejected, receiver keeps hunting.
    @(negedge Clk);
    RX = 1'b0;
    repeat (8) @(negedge Clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge Clk);
    check("glitch_nowrite", wq.size(), 0);
    check("glitch_fe", FE, 0);
    check("glitch_busy", Busy, 1);
    send_frame(8'h11, 1'b1, 0, -1, 0);
    check_frame("after_glitch", 1'b1, 5'd2, 8'h11, 1'b0);

    // Full load of Depth bytes, then the line is ignored.
    load_pulse();
    for (int b = 0; b < D; b++) begin
      send_frame(8'(b), 1'b1, 0, -1, 0);
      check_frame($sformatf("fill%0d", b), 1'b1, 5'(b), 8'(b), b == D - 1);
    end
    check("fill_busy_after", Busy, 0);
    check("fill_addr_hold", Wr_addr, D - 1);
    send_frame(8'h99, 1'b1, 0, -1, 0);
    check_frame("after_done", 1'b0, 5'd0, 8'h00, 1'b0);
    check("after_done_addr", Wr_addr, D - 1);

    // Load during data bit 4 of the third byte aborts it and clears FE.
    load_pulse();
    send_frame(8'h21, 1'b1, 0, -1, 0);
    check_frame("abort_b1", 1'b1, 5'd0, 8'h21, 1'b0);
    send_frame(8'h44, 1'b0, 0, -1, 0);
    check_frame("abort_b2", 1'b0, 5'd0, 8'h00, 1'b0);
    check("abort_fe_set", FE, 1);
    send_frame(8'hF5, 1'b1, 0, 5, 1);
    check_frame("abort_b3", 1'b0, 5'd0, 8'h00, 1'b0);
    check("abort_b3_addr", Wr_addr, 0);
    check("abort_b3_fe", FE, 0);
    send_frame(8'h33, 1'b1, 0, -1, 0);
    check_frame("abort_b4", 1'b1, 5'd0, 8'h33, 1'b0);

    // Reset during data bits of the fifth byte.
    load_pulse();
    for (int b = 0; b < 4; b++) begin
      send_frame(8'(8'h61 + b), 1'b1, 0, -1, 0);
      check_frame($sformatf("rst_b%0d", b), 1'b1, 5'(b), 8'(8'h61 + b), 1'b0);
    end
    send_frame(8'h96, 1'b1, 0, 3, 2);
    check_frame("rst_b5", 1'b0, 5'd0, 8'h00, 1'b0);
    send_frame(8'h5A, 1'b1, 0, -1, 0);
    check_frame("rst_ignored", 1'b0, 5'd0, 8'h00, 1'b0);
    check("rst_busy", Busy, 0);
    check("rst_addr", Wr_addr, 0);

    // Randomized frames against the byte-level model.
    load_pulse();
    model_load();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) begin
        load_pulse();
        model_load();
      end
      d = 8'($urandom);
      s = ($urandom_range(5) != 0);
      model_frame(s, ew, ea, ed);
      send_frame(d, s, 0, -1, 0);
      check_frame($sformatf("rand%0d", n), ew, ea, d, ed);
      check($sformatf("rand%0d_fe", n), FE, m_fe);
      check($sformatf("rand%0d_busy", n), Busy, m_active);
      check($sformatf("rand%0d_addr", n), Wr_addr, m_wa);
    end

    check("stray_done", stray_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
